// File: rtl/fpdiv_ctrl.sv
// Control sequencer for the Goldschmidt fpdiv datapath: seeds the estimates, runs ITER
// A/B refinement pairs, captures the remainder product and signals completion.
module fpdiv_ctrl #(
  parameter int ITER = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       ld_op,
  output logic       en_a,
  output logic       en_b,
  output logic       en_rem,
  output logic [1:0] sel_mux3,
  output logic [1:0] sel_mux4,
  output logic       busy,
  output logic       done,
  output logic [2:0] iter_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT_A = 3'd1,
    INIT_B = 3'd2,
    ITER_A = 3'd3,
    ITER_B = 3'd4,
    REM    = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [3:0] ITER_W = 4'(ITER);

  state_t     state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;
  logic [3:0] cnt_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign cnt_inc = {1'b0, cnt_reg} + 4'd1;

  always_comb begin
    state_next = IDLE;
    cnt_next   = cnt_reg;
    en_a       = 1'b0;
    en_b       = 1'b0;
    en_rem     = 1'b0;
    sel_mux3   = 2'd0;
    sel_mux4   = 2'd0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        state_next = start ? INIT_A : IDLE;
      end
      INIT_A: begin
        en_a       = 1'b1;
        busy       = 1'b1;
        state_next = INIT_B;
      end
      INIT_B: begin
        sel_mux4   = 2'd1;
        en_b       = 1'b1;
        busy       = 1'b1;
        cnt_next   = 3'd0;
        state_next = ITER_A;
      end
      ITER_A: begin
        sel_mux3   = 2'd1;
        sel_mux4   = 2'd2;
        en_a       = 1'b1;
        busy       = 1'b1;
        state_next = ITER_B;
      end
      ITER_B: begin
        sel_mux3 = 2'd1;
        sel_mux4 = 2'd3;
        en_b     = 1'b1;
        busy     = 1'b1;
        // Count saturates at ITER; the >= compare keeps the loop finite either way.
        if ({1'b0, cnt_reg} < ITER_W) cnt_next = cnt_inc[2:0];
        state_next = (cnt_inc >= ITER_W) ? REM : ITER_A;
      end
      REM: begin
        sel_mux3   = 2'd2;
        sel_mux4   = 2'd2;
        en_rem     = 1'b1;
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? INIT_A : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Reset beats start, so no operand load is requested while reset is asserted.
  assign ld_op    = start & ~reset & ((state_reg == IDLE) | (state_reg == DONE));
  assign iter_cnt = cnt_reg;

endmodule
